// File: rtl/serializer_pkg.sv
// Shared types and helpers for the handshake serializer.
package serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } ser_state_e;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_BIT_CYCLES = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/ser_bit_timer.sv
// Bit period timer: counts BIT_CYCLES cycles per serial bit and flags the last one.
module ser_bit_timer
    import serializer_pkg::*;
#(
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic bit_done
);

    localparam int CNT_W = cnt_w(BIT_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM);

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    generate
        if (BIT_CYCLES == 1) begin : g_single
            assign bit_done = 1'b1;
        end else begin : g_multi
            assign bit_done = at_term;
        end
    endgenerate

endmodule

// File: rtl/serializer_hs.sv
// Parallel-to-serial converter with a one-word holding buffer and valid/ready input.
module serializer_hs
    import serializer_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int LSB_FIRST  = 1,
    parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out,
    output logic             out_en,
    output logic             out_last,
    output logic             busy
);

    localparam int IDX_W = clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             buf_full_q, buf_full_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
    logic             out_q, out_d;
    logic             out_en_q, out_en_d;
    logic             out_last_q, out_last_d;

    logic             accept;
    logic             load;
    logic             bit_done;
    logic [WIDTH-1:0] shreg_next;
    logic [IDX_W-1:0] idx_next;

    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
    endfunction

    assign in_ready   = rst_n & ~buf_full_q;
    assign accept     = in_valid & in_ready;
    assign busy       = (state_q == ST_SHIFT) | buf_full_q;
    assign shreg_next = (LSB_FIRST != 0) ? (shreg_q >> 1) : (shreg_q << 1);
    assign idx_next   = bit_idx_q + IDX_W'(1);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        out_d      = out_q;
        out_en_d   = out_en_q;
        out_last_d = out_last_q;
        load       = 1'b0;

        // accept and load are mutually exclusive: accept needs an empty buffer, load a full one
        if (accept) begin
            buf_d      = in_data;
            buf_full_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (buf_full_q) load = 1'b1;
            end
            ST_SHIFT: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_IDX) begin
                        if (buf_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d    = ST_IDLE;
                            out_d      = 1'b0;
                            out_en_d   = 1'b0;
                            out_last_d = 1'b0;
                        end
                    end else begin
                        shreg_d    = shreg_next;
                        bit_idx_d  = idx_next;
                        out_d      = head_bit(shreg_next);
                        out_last_d = (idx_next == LAST_IDX);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load) begin
            state_d    = ST_SHIFT;
            shreg_d    = buf_q;
            buf_full_d = 1'b0;
            bit_idx_d  = '0;
            out_d      = head_bit(buf_q);
            out_en_d   = 1'b1;
            out_last_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            out_q      <= 1'b0;
            out_en_q   <= 1'b0;
            out_last_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            out_q      <= out_d;
            out_en_q   <= out_en_d;
            out_last_q <= out_last_d;
        end
    end

    // Timer restarts from zero whenever a word is loaded out of IDLE.
    ser_bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state_q != ST_SHIFT),
        .en      (state_q == ST_SHIFT),
        .bit_done(bit_done)
    );

    assign out      = out_q;
    assign out_en   = out_en_q;
    assign out_last = out_last_q;

endmodule

// File: tb/tb_serializer_hs.sv
// Scoreboard bench for serializer_hs: three configurations share clock and reset.
module tb_serializer_hs;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // a: WIDTH=8 LSB-first BIT_CYCLES=1; b: MSB-first; c: WIDTH=4 BIT_CYCLES=3
    logic       in_valid_a = 1'b0, in_ready_a, out_a, out_en_a, out_last_a, busy_a;
    logic [7:0] in_data_a = '0;
    logic       in_valid_b = 1'b0, in_ready_b, out_b, out_en_b, out_last_b, busy_b;
    logic [7:0] in_data_b = '0;
    logic       in_valid_c = 1'b0, in_ready_c, out_c, out_en_c, out_last_c, busy_c;
    logic [3:0] in_data_c = '0;

    serializer_hs #(.WIDTH(8), .LSB_FIRST(1), .BIT_CYCLES(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_a), .in_ready(in_ready_a),
        .in_data(in_data_a), .out(out_a), .out_en(out_en_a), .out_last(out_last_a), .busy(busy_a));
    serializer_hs #(.WIDTH(8), .LSB_FIRST(0), .BIT_CYCLES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_b), .in_ready(in_ready_b),
        .in_data(in_data_b), .out(out_b), .out_en(out_en_b), .out_last(out_last_b), .busy(busy_b));
    serializer_hs #(.WIDTH(4), .LSB_FIRST(1), .BIT_CYCLES(3)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_c), .in_ready(in_ready_c),
        .in_data(in_data_c), .out(out_c), .out_en(out_en_c), .out_last(out_last_c), .busy(busy_c));

    int checks = 0;
    int passed = 0;
    logic [1:0] qa[$], qb[$], qc[$];   // expected {out, out_last} per out_en cycle
    int run_a = 0, run_b = 0, run_c = 0;
    int last_run_a = 0, last_run_b = 0, last_run_c = 0;

    task automatic monitor();
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (out_en_a === 1'b1) begin
                checks++;
                if (qa.size() == 0) $display("FAIL mon_a_extra: out_en=1 out=%b, required out_en=0", out_a);
                else begin
                    e = qa.pop_front();
                    if ({out_a, out_last_a} !== e) $display("FAIL mon_a_bit: out/last=%b required %b", {out_a, out_last_a}, e);
                    else passed++;
                end
                run_a++;
            end else begin
                if (run_a != 0) last_run_a = run_a;
                run_a = 0;
            end
            if (out_en_b === 1'b1) begin
                checks++;
                if (qb.size() == 0) $display("FAIL mon_b_extra: out_en=1 out=%b, required out_en=0", out_b);
                else begin
                    e = qb.pop_front();
                    if ({out_b, out_last_b} !== e) $display("FAIL mon_b_bit: out/last=%b required %b", {out_b, out_last_b}, e);
                    else passed++;
                end
                run_b++;
            end else begin
                if (run_b != 0) last_run_b = run_b;
                run_b = 0;
            end
            if (out_en_c === 1'b1) begin
                checks++;
                if (qc.size() == 0) $display("FAIL mon_c_extra: out_en=1 out=%b, required out_en=0", out_c);
                else begin
                    e = qc.pop_front();
                    if ({out_c, out_last_c} !== e) $display("FAIL mon_c_bit: out/last=%b required %b", {out_c, out_last_c}, e);
                    else passed++;
                end
                run_c++;
            end else begin
                if (run_c != 0) last_run_c = run_c;
                run_c = 0;
            end
        end
    endtask

    task automatic send_a(input logic [7:0] w);
        logic rdy, acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid_a = 1'b1; in_data_a = w;
        for (int t = 0; t < 200; t++) begin
            rdy = in_ready_a;
            @(posedge clk); #1;
            if (rdy) begin acc = 1'b1; break; end
        end
        in_valid_a = 1'b0; in_data_a = 8'($urandom);
        if (!acc) begin checks++; $display("FAIL send_a_timeout: accepted=0 required 1"); end
        else for (int i = 0; i < 8; i++) qa.push_back({w[i], i == 7});
    endtask

    task automatic send_b(input logic [7:0] w);
        logic rdy, acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid_b = 1'b1; in_data_b = w;
        for (int t = 0; t < 200; t++) begin
            rdy = in_ready_b;
            @(posedge clk); #1;
            if (rdy) begin acc = 1'b1; break; end
        end
        in_valid_b = 1'b0; in_data_b = 8'($urandom);
        if (!acc) begin checks++; $display("FAIL send_b_timeout: accepted=0 required 1"); end
        else for (int i = 0; i < 8; i++) qb.push_back({w[7-i], i == 7});
    endtask

    task automatic send_c(input logic [3:0] w);
        logic rdy, acc;
        acc = 1'b0;
        @(posedge clk); #1;
        in_valid_c = 1'b1; in_data_c = w;
        for (int t = 0; t < 200; t++) begin
            rdy = in_ready_c;
            @(posedge clk); #1;
            if (rdy) begin acc = 1'b1; break; end
        end
        in_valid_c = 1'b0; in_data_c = 4'($urandom);
        if (!acc) begin checks++; $display("FAIL send_c_timeout: accepted=0 required 1"); end
        else for (int i = 0; i < 4; i++)
            for (int r = 0; r < 3; r++) qc.push_back({w[i], i == 3});
    endtask

    task automatic wait_done_a();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (!out_en_a && qa.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) begin checks++; $display("FAIL wait_a_timeout: pending=%0d required 0", qa.size()); end
    endtask

    task automatic wait_done_b();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (!out_en_b && qb.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) begin checks++; $display("FAIL wait_b_timeout: pending=%0d required 0", qb.size()); end
    endtask

    task automatic wait_done_c();
        logic done;
        done = 1'b0;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk); #1;
            if (!out_en_c && qc.size() == 0) begin done = 1'b1; break; end
        end
        if (!done) begin checks++; $display("FAIL wait_c_timeout: pending=%0d required 0", qc.size()); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        checks++;
        if ({out_a, out_en_a, out_last_a, busy_a, in_ready_a} !== 5'b0)
            $display("FAIL reset_a_outputs: %b required 00000", {out_a, out_en_a, out_last_a, busy_a, in_ready_a});
        else passed++;
        checks++;
        if ({out_en_c, busy_c, in_ready_c} !== 3'b0)
            $display("FAIL reset_c_outputs: %b required 000", {out_en_c, busy_c, in_ready_c});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if ({in_ready_a, in_ready_b, in_ready_c} !== 3'b111)
            $display("FAIL reset_release_ready: %b required 111", {in_ready_a, in_ready_b, in_ready_c});
        else passed++;
    endtask

    task automatic test_lsb_first();
        send_a(8'hA5);
        @(negedge clk); #1;
        checks++;
        if ({out_en_a, busy_a} !== 2'b01) $display("FAIL lsb_buffered: out_en/busy=%b required 01", {out_en_a, busy_a});
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({out_en_a, out_a} !== 2'b11) $display("FAIL lsb_latency: out_en/out=%b required 11", {out_en_a, out_a});
        else passed++;
        wait_done_a();
        checks++;
        if (last_run_a !== 8) $display("FAIL lsb_run_len: %0d required 8", last_run_a);
        else passed++;
        checks++;
        if ({busy_a, out_a, out_last_a} !== 3'b0) $display("FAIL lsb_idle: busy/out/last=%b required 000", {busy_a, out_a, out_last_a});
        else passed++;
    endtask

    task automatic test_msb_first();
        send_b(8'hA5);
        wait_done_b();
        checks++;
        if (last_run_b !== 8) $display("FAIL msb_run_len_a5: %0d required 8", last_run_b);
        else passed++;
        send_b(8'h01);
        wait_done_b();
        checks++;
        if (last_run_b !== 8) $display("FAIL msb_run_len_01: %0d required 8", last_run_b);
        else passed++;
        checks++;
        if (busy_b !== 1'b0) $display("FAIL msb_busy: %b required 0", busy_b);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic hit;
        send_a(8'hFF);
        send_a(8'h00);
        checks++;
        if ({in_ready_a, busy_a} !== 2'b01) $display("FAIL b2b_ready_after_accept: ready/busy=%b required 01", {in_ready_a, busy_a});
        else passed++;
        hit = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #1;
            if (qa.size() == 8) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || in_ready_a !== 1'b0) $display("FAIL b2b_ready_last_bit: ready=%b reached=%b required ready=0 reached=1", in_ready_a, hit);
        else passed++;
        @(negedge clk); #1;
        checks++;
        if ({in_ready_a, out_en_a} !== 2'b11) $display("FAIL b2b_reload: ready/out_en=%b required 11", {in_ready_a, out_en_a});
        else passed++;
        wait_done_a();
        checks++;
        if (last_run_a !== 16) $display("FAIL b2b_run_len: %0d required 16", last_run_a);
        else passed++;
    endtask

    task automatic test_bit_cycles();
        send_c(4'b0110);
        wait_done_c();
        checks++;
        if (last_run_c !== 12) $display("FAIL bitcyc_run_len: %0d required 12", last_run_c);
        else passed++;
        checks++;
        if (busy_c !== 1'b0) $display("FAIL bitcyc_busy: %b required 0", busy_c);
        else passed++;
    endtask

    task automatic test_valid_drop();
        logic fell;
        int extra;
        send_a(8'h5A);
        send_a(8'h3C);
        in_valid_a = 1'b1; in_data_a = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (in_ready_a !== 1'b0) $display("FAIL drop_ready_%0d: %b required 0", k, in_ready_a);
            else passed++;
            if (k < 2) begin @(posedge clk); #1; end
        end
        in_valid_a = 1'b0;
        fell = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #1;
            if (!out_en_a) begin fell = 1'b1; break; end
        end
        checks++;
        if (!fell || busy_a !== 1'b0) $display("FAIL drop_busy_falls: busy=%b fell=%b required busy=0 fell=1", busy_a, fell);
        else passed++;
        checks++;
        if (last_run_a !== 16) $display("FAIL drop_run_len: %0d required 16", last_run_a);
        else passed++;
        extra = 0;
        for (int t = 0; t < 12; t++) begin
            @(negedge clk); #1;
            if (out_en_a) extra++;
        end
        checks++;
        if (extra !== 0) $display("FAIL drop_extra_word: %0d bits required 0", extra);
        else passed++;
    endtask

    task automatic test_reset_mid_word();
        logic hit;
        int stale;
        send_a(8'hC3);
        send_a(8'h96);
        hit = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk); #1;
            if (qa.size() == 12) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || {out_en_a, in_ready_a} !== 2'b10) $display("FAIL rstmid_pre: out_en/ready=%b reached=%b required 10 reached=1", {out_en_a, in_ready_a}, hit);
        else passed++;
        rst_n = 1'b0;
        qa.delete();
        @(negedge clk); #1;
        checks++;
        if ({out_a, out_en_a, out_last_a, in_ready_a, busy_a} !== 5'b0)
            $display("FAIL rstmid_cleared: %b required 00000", {out_a, out_en_a, out_last_a, in_ready_a, busy_a});
        else passed++;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (in_ready_a !== 1'b1) $display("FAIL rstmid_ready: %b required 1", in_ready_a);
        else passed++;
        stale = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk); #1;
            if (out_en_a) stale++;
        end
        checks++;
        if (stale !== 0) $display("FAIL rstmid_stale_bits: %0d required 0", stale);
        else passed++;
    endtask

    initial begin
        fork
            monitor();
        join_none
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_back_to_back();
        test_bit_cycles();
        test_valid_drop();
        test_reset_mid_word();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
